// File: rtl/hazard_sb.sv
// hazard_sb: register scoreboard and divider sequencer for the in-order pipe.
// Tracks cycles-until-forwardable per architectural register, raises decode
// stalls on RAW and HI/LO hazards, and freezes the back end during a divide.

// Per-register countdown: cycles until the last in-flight write is forwardable to E.
module hazard_sb_cnt #(
  parameter int CW       = 2,
  parameter int LOAD_LAT = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          hold,
  input  logic          ld,
  input  logic          isLoad,
  output logic [CW-1:0] cnt
);
  // Fresh issue wins over the decrement; a divide freeze holds the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (ld)               cnt <= isLoad ? CW'(LOAD_LAT) : CW'(1);
    else if (!hold && cnt != '0) cnt <= cnt - CW'(1);
  end
endmodule

module hazard_sb #(
  parameter int REG_N    = 32,
  parameter int LOAD_LAT = 2,
  parameter int DIV_LAT  = 34
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     validD,
  input  logic [$clog2(REG_N)-1:0] rsD,
  input  logic [$clog2(REG_N)-1:0] rtD,
  input  logic                     rs_useD,
  input  logic                     rt_useD,
  input  logic                     brD,
  input  logic                     wenD,
  input  logic [$clog2(REG_N)-1:0] wregD,
  input  logic                     loadD,
  input  logic                     hilo_readD,
  input  logic                     div_startE,
  input  logic                     exc_i,
  output logic                     stallF,
  output logic                     stallD,
  output logic                     flushE,
  output logic                     stallE,
  output logic                     stallM,
  output logic                     stallW,
  output logic                     flush_all,
  output logic                     div_busy,
  output logic                     div_done
);
  localparam int RW = $clog2(REG_N);
  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam int DW = $clog2(DIV_LAT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} divSt_t;

  divSt_t                   divSt;
  logic [DW-1:0]            divCnt;
  logic [REG_N-1:0][CW-1:0] cnt;
  logic [CW-1:0]            rsCnt, rtCnt;
  logic                     rsHaz, rtHaz;
  logic                     rawStall, hiloStall, divStall, stallInt, issue;

  // r0 never has a pending write.
  assign cnt[0] = '0;

  for (genvar r = 1; r < REG_N; r++) begin : gReg
    hazard_sb_cnt #(.CW(CW), .LOAD_LAT(LOAD_LAT)) uCnt (
      .clk    (clk),
      .resetn (resetn),
      .clr    (exc_i),
      .hold   (divStall),
      .ld     (issue && (wregD == RW'(r))),
      .isLoad (loadD),
      .cnt    (cnt[r])
    );
  end

  // A branch reads in D, so it needs the value one cycle earlier than an E consumer.
  always_comb begin
    rsCnt = cnt[rsD];
    rtCnt = cnt[rtD];
    rsHaz = rs_useD && (rsD != '0) && (brD ? (rsCnt != '0) : (rsCnt > CW'(1)));
    rtHaz = rt_useD && (rtD != '0) && (brD ? (rtCnt != '0) : (rtCnt > CW'(1)));
  end

  assign rawStall  = validD & (rsHaz | rtHaz);
  assign hiloStall = validD & hilo_readD & (divSt != IDLE);
  // The start cycle itself stalls, so start + (DIV_LAT-1) BUSY cycles = DIV_LAT.
  assign divStall  = ((divSt == IDLE) & div_startE) | (divSt == BUSY);
  assign stallInt  = rawStall | hiloStall | divStall;
  assign issue     = validD & wenD & (wregD != '0) & ~stallInt & ~exc_i;

  // Divider sequencer; an exception aborts the divide without a done strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      divSt  <= IDLE;
      divCnt <= '0;
    end else if (exc_i) begin
      divSt  <= IDLE;
      divCnt <= '0;
    end else begin
      case (divSt)
        IDLE: if (div_startE) begin
          divSt  <= BUSY;
          divCnt <= DW'(DIV_LAT - 2);
        end
        BUSY: if (divCnt == '0) divSt <= DONE;
              else              divCnt <= divCnt - DW'(1);
        DONE: divSt <= IDLE;
        default: divSt <= IDLE;
      endcase
    end
  end

  // Outputs are held low through reset regardless of live decode inputs.
  always_comb begin
    stallF    = resetn & ~exc_i & stallInt;
    stallD    = resetn & ~exc_i & stallInt;
    flushE    = resetn & ~exc_i & (rawStall | hiloStall) & ~divStall;
    stallE    = resetn & ~exc_i & divStall;
    stallM    = resetn & ~exc_i & divStall;
    stallW    = resetn & ~exc_i & divStall;
    flush_all = resetn & exc_i;
    div_busy  = resetn & (divSt != IDLE);
    div_done  = resetn & (divSt == DONE);
  end
endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb: expected control vectors are queued as each
// step is driven and checked at the following falling edge.
module tb_hazard_sb;
  logic       clk = 1'b0;
  logic       resetn;
  logic       validD, rs_useD, rt_useD, brD, wenD, loadD, hilo_readD, div_startE, exc_i;
  logic [4:0] rsD, rtD, wregD;
  logic       stallF, stallD, flushE, stallE, stallM, stallW, flush_all, div_busy, div_done;

  typedef struct {
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  hazard_sb #(.REG_N(32), .LOAD_LAT(2), .DIV_LAT(34)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .validD     (validD),
    .rsD        (rsD),
    .rtD        (rtD),
    .rs_useD    (rs_useD),
    .rt_useD    (rt_useD),
    .brD        (brD),
    .wenD       (wenD),
    .wregD      (wregD),
    .loadD      (loadD),
    .hilo_readD (hilo_readD),
    .div_startE (div_startE),
    .exc_i      (exc_i),
    .stallF     (stallF),
    .stallD     (stallD),
    .flushE     (flushE),
    .stallE     (stallE),
    .stallM     (stallM),
    .stallW     (stallW),
    .flush_all  (flush_all),
    .div_busy   (div_busy),
    .div_done   (div_done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic clearIn();
    validD = 0; rs_useD = 0; rt_useD = 0; brD = 0; wenD = 0; loadD = 0;
    hilo_readD = 0; div_startE = 0; exc_i = 0;
    rsD = '0; rtD = '0; wregD = '0;
  endtask

  // Expected: front stall, flushE, back-end stall, flush_all, busy, done.
  task automatic pushExp(input string tag, input logic st, input logic fe, input logic bs,
                         input logic fa, input logic bz, input logic dn);
    exp_t e;
    e.tag = tag;
    e.v   = {st, st, fe, bs, bs, bs, fa, bz, dn};
    sb.push_back(e);
  endtask

  // Check queued expectations mid-cycle, then move to just after the next rising edge.
  task automatic tick();
    exp_t       e;
    logic [8:0] obs;
    @(negedge clk);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = {stallF, stallD, flushE, stallE, stallM, stallW, flush_all, div_busy, div_done};
      total++;
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearIn();
    resetn = 0;
    // Reset: outputs low even with live stall-inducing inputs.
    div_startE = 1; validD = 1; hilo_readD = 1; rsD = 5; rs_useD = 1;
    pushExp("rst_in", 0, 0, 0, 0, 0, 0); tick();
    exc_i = 1;
    pushExp("rst_exc", 0, 0, 0, 0, 0, 0); tick();
    clearIn(); resetn = 1;
    pushExp("idle", 0, 0, 0, 0, 0, 0); tick();

    // Load-use: one bubble, then the consumer advances.
    validD = 1; wenD = 1; wregD = 5; loadD = 1;
    pushExp("ld_r5", 0, 0, 0, 0, 0, 0); tick();
    clearIn(); validD = 1; rsD = 5; rs_useD = 1; wenD = 1; wregD = 6;
    pushExp("ld_use_stall", 1, 1, 0, 0, 0, 0); tick();
    pushExp("ld_use_go", 0, 0, 0, 0, 0, 0); tick();
    clearIn();
    pushExp("ld_after", 0, 0, 0, 0, 0, 0); tick();

    // ALU producer: a branch consumer stalls once, an E consumer not at all.
    validD = 1; wenD = 1; wregD = 7;
    pushExp("alu_r7", 0, 0, 0, 0, 0, 0); tick();
    clearIn(); validD = 1; brD = 1; rsD = 7; rs_useD = 1;
    pushExp("alu_br_stall", 1, 1, 0, 0, 0, 0); tick();
    pushExp("alu_br_go", 0, 0, 0, 0, 0, 0); tick();
    clearIn(); validD = 1; wenD = 1; wregD = 7;
    pushExp("alu_r7b", 0, 0, 0, 0, 0, 0); tick();
    clearIn(); validD = 1; rtD = 7; rt_useD = 1;
    pushExp("alu_add_go", 0, 0, 0, 0, 0, 0); tick();

    // Load feeding a branch: two bubbles.
    clearIn(); validD = 1; wenD = 1; wregD = 8; loadD = 1;
    pushExp("ld_r8", 0, 0, 0, 0, 0, 0); tick();
    clearIn(); validD = 1; brD = 1; rsD = 8; rs_useD = 1;
    pushExp("ld_br_s1", 1, 1, 0, 0, 0, 0); tick();
    pushExp("ld_br_s2", 1, 1, 0, 0, 0, 0); tick();
    pushExp("ld_br_go", 0, 0, 0, 0, 0, 0); tick();

    // r0 writes/reads and unused sources never stall.
    clearIn(); validD = 1; wenD = 1; wregD = 0; loadD = 1;
    pushExp("ld_r0", 0, 0, 0, 0, 0, 0); tick();
    clearIn(); validD = 1; brD = 1; rs_useD = 1; rt_useD = 1;
    pushExp("r0_read", 0, 0, 0, 0, 0, 0); tick();
    clearIn(); validD = 1; wenD = 1; wregD = 9; loadD = 1;
    pushExp("ld_r9", 0, 0, 0, 0, 0, 0); tick();
    clearIn(); validD = 1; brD = 1; rsD = 9; rtD = 9;
    pushExp("unused_src", 0, 0, 0, 0, 0, 0); tick();
    clearIn(); validD = 1; hilo_readD = 1;
    pushExp("mfhi_idle", 0, 0, 0, 0, 0, 0); tick();
    clearIn();
    pushExp("idle2", 0, 0, 0, 0, 0, 0); tick();

    // Divide with mfhi waiting in D; start held high through BUSY is ignored.
    div_startE = 1; validD = 1; hilo_readD = 1;
    pushExp("div_start", 1, 0, 1, 0, 0, 0); tick();
    for (int i = 0; i < 33; i++) begin
      pushExp("div_busy", 1, 0, 1, 0, 1, 0); tick();
    end
    div_startE = 0;
    pushExp("div_done", 1, 1, 0, 0, 1, 1); tick();
    pushExp("div_idle", 0, 0, 0, 0, 0, 0); tick();

    // Counters freeze while the divide stalls the machine.
    clearIn(); validD = 1; wenD = 1; wregD = 10; loadD = 1;
    pushExp("ld_r10", 0, 0, 0, 0, 0, 0); tick();
    clearIn(); div_startE = 1;
    pushExp("frz_start", 1, 0, 1, 0, 0, 0); tick();
    clearIn(); validD = 1; rsD = 10; rs_useD = 1;
    for (int i = 0; i < 33; i++) begin
      pushExp("frz_busy", 1, 0, 1, 0, 1, 0); tick();
    end
    pushExp("frz_done_raw", 1, 1, 0, 0, 1, 1); tick();
    pushExp("frz_go", 0, 0, 0, 0, 0, 0); tick();

    // Exception mid-divide: flush, abort, clear the scoreboard.
    clearIn(); validD = 1; wenD = 1; wregD = 3; loadD = 1;
    pushExp("ld_r3", 0, 0, 0, 0, 0, 0); tick();
    clearIn(); div_startE = 1;
    pushExp("div2_start", 1, 0, 1, 0, 0, 0); tick();
    clearIn(); validD = 1; brD = 1; rsD = 3; rs_useD = 1; exc_i = 1;
    pushExp("exc_flush", 0, 0, 0, 1, 1, 0); tick();
    exc_i = 0;
    pushExp("exc_after", 0, 0, 0, 0, 0, 0); tick();
    clearIn();
    for (int i = 0; i < 3; i++) begin
      pushExp("exc_nodone", 0, 0, 0, 0, 0, 0); tick();
    end

    // Reset mid-divide: outputs drop at once, no done afterwards, counters cleared.
    validD = 1; wenD = 1; wregD = 4; loadD = 1;
    pushExp("ld_r4", 0, 0, 0, 0, 0, 0); tick();
    clearIn(); div_startE = 1;
    pushExp("div3_start", 1, 0, 1, 0, 0, 0); tick();
    clearIn();
    for (int i = 0; i < 2; i++) begin
      pushExp("div3_busy", 1, 0, 1, 0, 1, 0); tick();
    end
    resetn = 0; validD = 1; hilo_readD = 1; div_startE = 1;
    pushExp("rst_mid", 0, 0, 0, 0, 0, 0); tick();
    clearIn(); resetn = 1; validD = 1; brD = 1; rsD = 4; rs_useD = 1;
    pushExp("rst_after", 0, 0, 0, 0, 0, 0); tick();
    clearIn();
    for (int i = 0; i < 3; i++) begin
      pushExp("rst_nodone", 0, 0, 0, 0, 0, 0); tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_sb.md
HAZARD_SB -- requirements
Module: hazard_sb

Interface
REQ-001 Parameter REG_N, default 32: architectural register count; register 0 is hard-wired zero.
REQ-002 Parameter LOAD_LAT, default 2: cycles from issue until a load result is forwardable to E; legal range 1..7.
REQ-003 Parameter DIV_LAT, default 34: total stall cycles for one divide; legal range >= 2.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 validD  in  1  a valid instruction is present in decode.
REQ-007 rsD, rtD  in  clog2(REG_N)  decode source register numbers.
REQ-008 rs_useD, rt_useD  in  1  the corresponding source is actually read.
REQ-009 brD  in  1  the decode instruction consumes its sources in D (branch or jr).
REQ-010 wenD, wregD  in  1, clog2(REG_N)  the decode instruction writes wregD.
REQ-011 loadD  in  1  the decode producer is a load (latency LOAD_LAT, else latency 1).
REQ-012 hilo_readD  in  1  the decode instruction is mfhi or mflo.
REQ-013 div_startE  in  1  a divide is in E and requests the divider.
REQ-014 exc_i  in  1  an exception or eret commits this cycle.
REQ-015 stallF, stallD, flushE  out  1  front-end control.
REQ-016 stallE, stallM, stallW  out  1  back-end freeze.
REQ-017 flush_all  out  1  flush every stage.
REQ-018 div_busy, div_done  out  1  divider status; div_done is a one-cycle HI/LO write strobe.

Function
REQ-019 Scoreboard: one counter cnt[r] per register, width clog2(LOAD_LAT+1); cnt[0] SHALL always read 0.
REQ-020 cnt[r] = cycles remaining until r is forwardable to a consumer in E.
REQ-021 raw_stall SHALL assert when validD and, for either used source s != 0, cnt[s] > 1 (brD=0) or cnt[s] > 0 (brD=1).
REQ-022 issue = validD & wenD & wregD != 0 & ~stallD & ~exc_i.
REQ-023 On issue, cnt[wregD] SHALL be loaded with LOAD_LAT if loadD, else 1.
REQ-024 Issue load SHALL take priority over the decrement of the same register in the same cycle.
REQ-025 Every other nonzero counter SHALL decrement by 1 per cycle.
REQ-026 No counter SHALL decrement while div_stall is asserted.
REQ-027 Divider FSM states:
- IDLE -> BUSY on div_startE.
- BUSY held for DIV_LAT-1 cycles, counted by an internal down-counter.
- BUSY -> DONE when the down-counter expires.
- DONE -> IDLE after one cycle.
REQ-028 div_stall = (IDLE & div_startE) | BUSY, giving exactly DIV_LAT stall cycles per divide.
REQ-029 div_busy = state != IDLE.
REQ-030 div_done SHALL be 1 only in DONE.
REQ-031 hilo_stall = validD & hilo_readD & (state != IDLE).
REQ-032 Control equations when exc_i = 0:
- stallF = stallD = raw_stall | hilo_stall | div_stall.
- flushE = (raw_stall | hilo_stall) & ~div_stall.
- stallE = stallM = stallW = div_stall.
REQ-033 exc_i = 1: flush_all = 1, all stall and flushE outputs forced 0, all counters cleared to 0 at the next edge, FSM forced to IDLE (divide aborted, no div_done).
REQ-034 div_startE while the FSM is not IDLE SHALL be ignored.

Reset
REQ-035 resetn low SHALL immediately force all counters to 0, the FSM to IDLE and the divide counter to 0.
REQ-036 While resetn is low, every output SHALL be 0.
REQ-037 Reset asserted mid-divide SHALL abort the divide without a div_done pulse.

Verification
REQ-038 Load to r5 issued, dependent add (rs=5) in D next cycle -> stallD=1 and flushE=1 for exactly 1 cycle; add advances the following cycle (LOAD_LAT=2).
REQ-039 ALU write r7, dependent beq (rs=7) next cycle -> 1 stall cycle; the same dependence with a non-branch consumer -> 0 stall cycles.
REQ-040 div_startE=1 with DIV_LAT=34 -> stallE/M/W high for exactly 34 cycles, div_done high in cycle 35; mfhi in D stalls until the FSM returns to IDLE.
REQ-041 exc_i pulse in BUSY with cnt[3]=2 -> flush_all=1 that cycle, next cycle div_busy=0, cnt[3]=0, no div_done.
REQ-042 Writes to r0 and reads of r0 -> never stall; resetn low mid-divide -> all outputs 0 immediately.
